// File: rtl/led_step_counter.sv
// Modulo-N step counter with prescaler: up-wrap, down-wrap, ping-pong and hold modes.
// Latency: count/dir/tick/tc update on the same edge that samples a step; a load shows next cycle.
// Backpressure: none; i_enable pauses the prescaler and stepping cycle-for-cycle.
//
// Ports:
//   i_clock      system clock, all state on the rising edge
//   i_reset      synchronous active-high reset
//   i_enable     qualifies prescaler advance and stepping
//   i_mode       00 up-wrap, 01 down-wrap, 10 ping-pong, 11 hold
//   i_load       synchronous load strobe (beats a step in the same cycle)
//   i_load_value value to load, clamped to MODULUS-1
//   o_count      current count, registered
//   o_dir        current direction (0 up, 1 down), registered
//   o_tick       one-cycle pulse while the newly stepped count is visible
//   o_tc         one-cycle pulse after a wrap or a ping-pong reversal
module led_step_counter #(
   parameter int WIDTH    = 3,
   parameter int MODULUS  = 8,
   parameter int PRESCALE = 1
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_enable,
   input  logic [1:0]       i_mode,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_value,
   output logic [WIDTH-1:0] o_count,
   output logic             o_dir,
   output logic             o_tick,
   output logic             o_tc
);

   generate
      if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH) ||
          PRESCALE < 1 || PRESCALE > 65536) begin : g_bad_param
         $error("led_step_counter: illegal WIDTH/MODULUS/PRESCALE");
      end
   endgenerate

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   localparam logic [PW-1:0]    P_LAST   = PW'(PRESCALE - 1);
   localparam logic [PW-1:0]    P_ONE    = PW'(1);
   localparam logic [WIDTH-1:0] C_MAX    = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] C_MAX_M1 = WIDTH'(MODULUS - 2);
   localparam logic [WIDTH-1:0] C_ONE    = WIDTH'(1);
   localparam logic [WIDTH-1:0] C_ZERO   = '0;

   localparam logic [1:0] MODE_UP   = 2'b00;
   localparam logic [1:0] MODE_DOWN = 2'b01;
   localparam logic [1:0] MODE_PING = 2'b10;
   localparam logic [1:0] MODE_HOLD = 2'b11;

   logic [WIDTH-1:0] r_count;
   logic             r_dir;
   logic             r_tick;
   logic             r_tc;
   logic [PW-1:0]    r_pre;

   logic             w_run;
   logic             w_step;
   logic [WIDTH-1:0] w_cnt_nxt;
   logic             w_dir_nxt;
   logic             w_wrap;
   logic [WIDTH-1:0] w_load_clamped;
   logic             w_load_dir;

   // Prescaler advances only when enabled and not in hold.
   assign w_run  = i_enable && (i_mode != MODE_HOLD);
   assign w_step = w_run && (r_pre == P_LAST);

   assign w_load_clamped = (i_load_value > C_MAX) ? C_MAX : i_load_value;

   // Loading an end point forces the direction a ping-pong would have there.
   always_comb begin
      w_load_dir = r_dir;
      if (w_load_clamped == C_ZERO)
         w_load_dir = 1'b0;
      else if (w_load_clamped == C_MAX && i_mode == MODE_PING)
         w_load_dir = 1'b1;
   end

   // Candidate next count/direction if this cycle steps. Explicit end-point
   // compares keep non-power-of-two moduli inside 0..MODULUS-1.
   always_comb begin
      w_cnt_nxt = r_count;
      w_dir_nxt = r_dir;
      w_wrap    = 1'b0;
      case (i_mode)
         MODE_UP: begin
            w_dir_nxt = 1'b0;
            if (r_count == C_MAX) begin
               w_cnt_nxt = C_ZERO;
               w_wrap    = 1'b1;
            end else begin
               w_cnt_nxt = r_count + C_ONE;
            end
         end
         MODE_DOWN: begin
            w_dir_nxt = 1'b1;
            if (r_count == C_ZERO) begin
               w_cnt_nxt = C_MAX;
               w_wrap    = 1'b1;
            end else begin
               w_cnt_nxt = r_count - C_ONE;
            end
         end
         MODE_PING: begin
            if (!r_dir) begin
               if (r_count != C_MAX) begin
                  w_cnt_nxt = r_count + C_ONE;
               end else begin
                  w_cnt_nxt = C_MAX_M1;
                  w_dir_nxt = 1'b1;
                  w_wrap    = 1'b1;
               end
            end else begin
               if (r_count != C_ZERO) begin
                  w_cnt_nxt = r_count - C_ONE;
               end else begin
                  w_cnt_nxt = C_ONE;
                  w_dir_nxt = 1'b0;
                  w_wrap    = 1'b1;
               end
            end
         end
         default: begin
            w_cnt_nxt = r_count;
            w_dir_nxt = r_dir;
            w_wrap    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_count <= C_ZERO;
         r_dir   <= 1'b0;
         r_tick  <= 1'b0;
         r_tc    <= 1'b0;
         r_pre   <= '0;
      end else if (i_load) begin
         r_count <= w_load_clamped;
         r_dir   <= w_load_dir;
         r_tick  <= 1'b0;
         r_tc    <= 1'b0;
         r_pre   <= '0;
      end else begin
         r_tick <= w_step;
         r_tc   <= w_step && w_wrap;
         if (w_step) begin
            r_count <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
         end
         if (w_run)
            r_pre <= w_step ? '0 : r_pre + P_ONE;
      end
   end

   assign o_count = r_count;
   assign o_dir   = r_dir;
   assign o_tick  = r_tick;
   assign o_tc    = r_tc;

endmodule

// File: tb/tb_led_step_counter.sv
// Directed bench for led_step_counter using four parameterisations on shared inputs.
// Each test task resets, drives stimulus and compares {count,dir,tick,tc} against hand-computed values.
module tb_led_step_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en  = 1'b0;
   logic [1:0] mode = 2'b00;
   logic       ld  = 1'b0;
   logic [2:0] lv  = 3'd0;

   logic [2:0] c0, c1, c2, c3;
   logic       d0, d1, d2, d3;
   logic       t0, t1, t2, t3;
   logic       k0, k1, k2, k3;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   // u0: defaults, u1: MODULUS=6, u2: MODULUS=4, u3: PRESCALE=3
   led_step_counter #(.WIDTH(3), .MODULUS(8), .PRESCALE(1)) u0 (
      .i_clock(clk), .i_reset(rst), .i_enable(en), .i_mode(mode), .i_load(ld),
      .i_load_value(lv), .o_count(c0), .o_dir(d0), .o_tick(t0), .o_tc(k0));
   led_step_counter #(.WIDTH(3), .MODULUS(6), .PRESCALE(1)) u1 (
      .i_clock(clk), .i_reset(rst), .i_enable(en), .i_mode(mode), .i_load(ld),
      .i_load_value(lv), .o_count(c1), .o_dir(d1), .o_tick(t1), .o_tc(k1));
   led_step_counter #(.WIDTH(3), .MODULUS(4), .PRESCALE(1)) u2 (
      .i_clock(clk), .i_reset(rst), .i_enable(en), .i_mode(mode), .i_load(ld),
      .i_load_value(lv), .o_count(c2), .o_dir(d2), .o_tick(t2), .o_tc(k2));
   led_step_counter #(.WIDTH(3), .MODULUS(8), .PRESCALE(3)) u3 (
      .i_clock(clk), .i_reset(rst), .i_enable(en), .i_mode(mode), .i_load(ld),
      .i_load_value(lv), .o_count(c3), .o_dir(d3), .o_tick(t3), .o_tc(k3));

   // Advance one clock and settle just after the edge.
   task automatic clk1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      ld  = 1'b0;
      clk1();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      logic [5:0] exp;
      mode = 2'b00;
      en   = 1'b1;
      do_reset();
      exp = 6'd0;
      n_checks++;
      if ({c0, d0, t0, k0} !== exp) $display("FAIL reset_u0: got %b expected %b", {c0, d0, t0, k0}, exp);
      else n_pass++;
      n_checks++;
      if ({c1, d1, t1, k1} !== exp) $display("FAIL reset_u1: got %b expected %b", {c1, d1, t1, k1}, exp);
      else n_pass++;
      n_checks++;
      if ({c2, d2, t2, k2} !== exp) $display("FAIL reset_u2: got %b expected %b", {c2, d2, t2, k2}, exp);
      else n_pass++;
      n_checks++;
      if ({c3, d3, t3, k3} !== exp) $display("FAIL reset_u3: got %b expected %b", {c3, d3, t3, k3}, exp);
      else n_pass++;
   endtask

   // Defaults, up-wrap: 1..7,0,1 with tick every cycle and tc only on 7->0.
   task automatic test_up_wrap;
      logic [5:0] exp;
      mode = 2'b00;
      en   = 1'b1;
      do_reset();
      for (int i = 1; i <= 9; i++) begin
         clk1();
         exp = {3'(i % 8), 1'b0, 1'b1, (i == 8)};
         n_checks++;
         if ({c0, d0, t0, k0} !== exp)
            $display("FAIL up_wrap step %0d: got cnt/dir/tick/tc %b expected %b", i, {c0, d0, t0, k0}, exp);
         else n_pass++;
      end
   endtask

   // MODULUS=6 down-wrap from reset: 5,4,3,2,1,0,5; tc on both 0->5 wraps.
   task automatic test_down_wrap;
      logic [2:0] exp_c [7] = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5};
      logic       exp_k [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [5:0] exp;
      mode = 2'b01;
      en   = 1'b1;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         clk1();
         exp = {exp_c[i], 1'b1, 1'b1, exp_k[i]};
         n_checks++;
         if ({c1, d1, t1, k1} !== exp)
            $display("FAIL down_wrap step %0d: got %b expected %b", i, {c1, d1, t1, k1}, exp);
         else n_pass++;
      end
   endtask

   // MODULUS=4 ping-pong: 1,2,3,2,1,0,1,2; reversals at 3->2 and 0->1.
   task automatic test_ping_pong;
      logic [2:0] exp_c [8] = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2};
      logic       exp_d [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic       exp_k [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [5:0] exp;
      mode = 2'b10;
      en   = 1'b1;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         clk1();
         exp = {exp_c[i], exp_d[i], 1'b1, exp_k[i]};
         n_checks++;
         if ({c2, d2, t2, k2} !== exp)
            $display("FAIL ping_pong step %0d: got %b expected %b", i, {c2, d2, t2, k2}, exp);
         else n_pass++;
      end
   endtask

   // PRESCALE=3: step every third cycle; a 2-cycle enable gap delays the next step by 2.
   task automatic test_prescale;
      logic [2:0] exp_c [6] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2};
      logic       exp_t [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [2:0] gap_c [4] = '{3'd2, 3'd2, 3'd2, 3'd3};
      logic       gap_t [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic       gap_e [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      mode = 2'b00;
      en   = 1'b1;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         clk1();
         n_checks++;
         if ({c3, t3} !== {exp_c[i], exp_t[i]})
            $display("FAIL prescale edge %0d: got cnt %0d tick %b expected cnt %0d tick %b",
                     i, c3, t3, exp_c[i], exp_t[i]);
         else n_pass++;
      end
      clk1();  // prescaler now at 1
      for (int i = 0; i < 4; i++) begin
         en = gap_e[i];
         clk1();
         n_checks++;
         if ({c3, t3} !== {gap_c[i], gap_t[i]})
            $display("FAIL prescale_gap edge %0d: got cnt %0d tick %b expected cnt %0d tick %b",
                     i, c3, t3, gap_c[i], gap_t[i]);
         else n_pass++;
      end
      en = 1'b1;
   endtask

   // MODULUS=6: clamped load, load beating a step, hold freeze, load direction rules.
   task automatic test_load_hold;
      logic [5:0] exp;
      mode = 2'b00;
      en   = 1'b1;
      do_reset();
      clk1();
      clk1();
      ld = 1'b1; lv = 3'd7;
      clk1();
      exp = {3'd5, 1'b0, 1'b0, 1'b0};
      n_checks++;
      if ({c1, d1, t1, k1} !== exp) $display("FAIL load_clamp: got %b expected %b", {c1, d1, t1, k1}, exp);
      else n_pass++;
      ld = 1'b0;
      clk1();
      exp = {3'd0, 1'b0, 1'b1, 1'b1};
      n_checks++;
      if ({c1, d1, t1, k1} !== exp) $display("FAIL load_then_wrap: got %b expected %b", {c1, d1, t1, k1}, exp);
      else n_pass++;
      ld = 1'b1; lv = 3'd2;
      clk1();
      exp = {3'd2, 1'b0, 1'b0, 1'b0};
      n_checks++;
      if ({c1, d1, t1, k1} !== exp) $display("FAIL load_over_step: got %b expected %b", {c1, d1, t1, k1}, exp);
      else n_pass++;
      ld = 1'b0;
      clk1();
      exp = {3'd3, 1'b0, 1'b1, 1'b0};
      n_checks++;
      if ({c1, d1, t1, k1} !== exp) $display("FAIL step_after_load: got %b expected %b", {c1, d1, t1, k1}, exp);
      else n_pass++;
      mode = 2'b11;
      for (int i = 0; i < 5; i++) begin
         clk1();
         exp = {3'd3, 1'b0, 1'b0, 1'b0};
         n_checks++;
         if ({c1, d1, t1, k1} !== exp) $display("FAIL hold cycle %0d: got %b expected %b", i, {c1, d1, t1, k1}, exp);
         else n_pass++;
      end
      mode = 2'b10; ld = 1'b1; lv = 3'd7;
      clk1();
      exp = {3'd5, 1'b1, 1'b0, 1'b0};
      n_checks++;
      if ({c1, d1, t1, k1} !== exp) $display("FAIL load_max_ping: got %b expected %b", {c1, d1, t1, k1}, exp);
      else n_pass++;
      ld = 1'b0;
      clk1();
      exp = {3'd4, 1'b1, 1'b1, 1'b0};
      n_checks++;
      if ({c1, d1, t1, k1} !== exp) $display("FAIL ping_down_after_load: got %b expected %b", {c1, d1, t1, k1}, exp);
      else n_pass++;
      ld = 1'b1; lv = 3'd0;
      clk1();
      exp = {3'd0, 1'b0, 1'b0, 1'b0};
      n_checks++;
      if ({c1, d1, t1, k1} !== exp) $display("FAIL load_zero_dir: got %b expected %b", {c1, d1, t1, k1}, exp);
      else n_pass++;
      ld = 1'b0;
      clk1();
      exp = {3'd1, 1'b0, 1'b1, 1'b0};
      n_checks++;
      if ({c1, d1, t1, k1} !== exp) $display("FAIL ping_up_after_zero: got %b expected %b", {c1, d1, t1, k1}, exp);
      else n_pass++;
   endtask

   // Reset beats a simultaneous load mid ping-pong; first step then P cycles later.
   task automatic test_reset_mid;
      logic [5:0] exp;
      mode = 2'b10;
      en   = 1'b1;
      do_reset();
      for (int i = 0; i < 5; i++) clk1();
      exp = {3'd1, 1'b1, 1'b1, 1'b0};
      n_checks++;
      if ({c2, d2, t2, k2} !== exp) $display("FAIL pre_reset_state: got %b expected %b", {c2, d2, t2, k2}, exp);
      else n_pass++;
      rst = 1'b1; ld = 1'b1; lv = 3'd3;
      clk1();
      exp = 6'd0;
      n_checks++;
      if ({c2, d2, t2, k2} !== exp) $display("FAIL reset_over_load: got %b expected %b", {c2, d2, t2, k2}, exp);
      else n_pass++;
      rst = 1'b0; ld = 1'b0;
      clk1();
      exp = {3'd1, 1'b0, 1'b1, 1'b0};
      n_checks++;
      if ({c2, d2, t2, k2} !== exp) $display("FAIL first_step_p1: got %b expected %b", {c2, d2, t2, k2}, exp);
      else n_pass++;
      n_checks++;
      if ({c3, d3, t3, k3} !== 6'd0) $display("FAIL p3_no_step_1: got %b expected %b", {c3, d3, t3, k3}, 6'd0);
      else n_pass++;
      clk1();
      n_checks++;
      if ({c3, d3, t3, k3} !== 6'd0) $display("FAIL p3_no_step_2: got %b expected %b", {c3, d3, t3, k3}, 6'd0);
      else n_pass++;
      clk1();
      exp = {3'd1, 1'b0, 1'b1, 1'b0};
      n_checks++;
      if ({c3, d3, t3, k3} !== exp) $display("FAIL first_step_p3: got %b expected %b", {c3, d3, t3, k3}, exp);
      else n_pass++;
   endtask

   initial begin
      clk1();
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_ping_pong();
      test_prescale();
      test_load_hold();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
